// File: rtl/whac_pkg.sv
// Shared types and helpers for the whac-a-mole mole generator.
package whac_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        RUNNING,
        EXPIRED
    } mole_gen_state_t;

    localparam logic [1:0] LVL_NONE = 2'd0;
    localparam logic [1:0] LVL_1    = 2'd1;
    localparam logic [1:0] LVL_2    = 2'd2;
    localparam logic [1:0] LVL_3    = 2'd3;

    localparam int NUM_MOLES_DEF = 18;

    // Level 0 falls back to the level-1 lifetime.
    function automatic logic [15:0] lvl_duration_ms(
        input logic [1:0]  level,
        input logic [15:0] l1,
        input logic [15:0] l2,
        input logic [15:0] l3
    );
        case (level)
            LVL_2:   return l2;
            LVL_3:   return l3;
            default: return l1;
        endcase
    endfunction

endpackage

// File: rtl/mole_lfsr.sv
// Free-running 16-bit Galois LFSR (mask 0xB400) with an all-zero recovery guard.
module mole_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] lfsr
);

    localparam logic [15:0] MASK = 16'hB400;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lfsr <= SEED;
        else if (lfsr == 16'h0000)
            lfsr <= SEED;
        else if (lfsr[0])
            lfsr <= {1'b0, lfsr[15:1]} ^ MASK;
        else
            lfsr <= {1'b0, lfsr[15:1]};
    end

endmodule

// File: rtl/mole_generator.sv
// Responder side of the whac-a-mole handshake: picks a mole on request and
// times its lifetime at a level-dependent duration.
//
// state   | meaning
// IDLE    | no mole shown, waiting for ready_for_mole
// ARMED   | mole shown, countdown frozen until timeout_start
// RUNNING | mole shown, millisecond countdown active
// EXPIRED | lifetime elapsed, timeout held low until the next load
module mole_generator
    import whac_pkg::*;
#(
    parameter int          NUM_MOLES = NUM_MOLES_DEF,
    parameter int          CLK_HZ    = 50_000_000,
    parameter int          LVL1_MS   = 1500,
    parameter int          LVL2_MS   = 1000,
    parameter int          LVL3_MS   = 600,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ready_for_mole,
    input  logic                 timeout_start,
    input  logic [1:0]           level_number,
    output logic [NUM_MOLES-1:0] led_number,
    output logic                 timeout,
    output logic [4:0]           mole_index
);

    localparam int TICKS_PER_MS = CLK_HZ / 1000;
    localparam int PW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(TICKS_PER_MS - 1);
    localparam logic [5:0]    NM      = 6'(NUM_MOLES);

    mole_gen_state_t state, state_nxt;
    logic [1:0]           level_reg, level_nxt;
    logic [15:0]          ms_cnt, ms_nxt;
    logic [PW-1:0]        prescaler, ps_nxt;
    logic [4:0]           prev_index, prev_nxt;
    logic [NUM_MOLES-1:0] led_nxt;
    logic [4:0]           idx_nxt;
    logic                 to_nxt;

    logic [15:0] lfsr;
    logic        unused_lfsr_hi;
    logic [5:0]  c0, c1, c2;
    logic [4:0]  pick;

    mole_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .lfsr  (lfsr)
    );

    assign unused_lfsr_hi = ^lfsr[15:5];

    // Fold the 5-bit random value into range, then step past the last mole.
    always_comb begin
        c0 = {1'b0, lfsr[4:0]};
        c1 = (c0 >= NM) ? c0 - NM : c0;
        c2 = (c1 >= NM) ? c1 - NM : c1;
        if (c2[4:0] == prev_index)
            pick = (c2 == NM - 6'd1) ? 5'd0 : c2[4:0] + 5'd1;
        else
            pick = c2[4:0];
    end

    always_comb begin
        state_nxt = state;
        level_nxt = level_reg;
        ms_nxt    = ms_cnt;
        ps_nxt    = prescaler;
        prev_nxt  = prev_index;
        led_nxt   = led_number;
        idx_nxt   = mole_index;
        to_nxt    = timeout;

        if ((state == IDLE || state == EXPIRED) && level_number != LVL_NONE)
            level_nxt = level_number;

        // A new request always wins, even over the final tick.
        if (ready_for_mole) begin
            led_nxt   = {{(NUM_MOLES-1){1'b0}}, 1'b1} << pick;
            idx_nxt   = pick;
            prev_nxt  = pick;
            to_nxt    = 1'b1;
            ms_nxt    = lvl_duration_ms(level_reg, 16'(LVL1_MS), 16'(LVL2_MS), 16'(LVL3_MS));
            ps_nxt    = '0;
            state_nxt = ARMED;
        end else begin
            case (state)
                ARMED, RUNNING: begin
                    if (timeout_start) begin
                        state_nxt = RUNNING;
                        if (prescaler == PS_LAST) begin
                            ps_nxt = '0;
                            if (ms_cnt == 16'd1) begin
                                ms_nxt    = '0;
                                to_nxt    = 1'b0;
                                led_nxt   = '0;
                                state_nxt = EXPIRED;
                            end else begin
                                ms_nxt = ms_cnt - 16'd1;
                            end
                        end else begin
                            ps_nxt = prescaler + 1'b1;
                        end
                    end else if (state == RUNNING) begin
                        led_nxt   = '0;
                        to_nxt    = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            level_reg  <= LVL_1;
            ms_cnt     <= '0;
            prescaler  <= '0;
            prev_index <= '0;
            led_number <= '0;
            mole_index <= '0;
            timeout    <= 1'b1;
        end else begin
            state      <= state_nxt;
            level_reg  <= level_nxt;
            ms_cnt     <= ms_nxt;
            prescaler  <= ps_nxt;
            prev_index <= prev_nxt;
            led_number <= led_nxt;
            mole_index <= idx_nxt;
            timeout    <= to_nxt;
        end
    end

endmodule

// File: tb/tb_mole_generator.sv
// Directed bench for mole_generator with a 4-cycle millisecond and short lifetimes.
module tb_mole_generator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ready_for_mole = 1'b0;
    logic        timeout_start = 1'b0;
    logic [1:0]  level_number = 2'd0;
    logic [17:0] led_number;
    logic        timeout;
    logic [4:0]  mole_index;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] m_lfsr;
    int          m_prev = 0;

    mole_generator #(
        .NUM_MOLES (18),
        .CLK_HZ    (4000),
        .LVL1_MS   (3),
        .LVL2_MS   (2),
        .LVL3_MS   (1),
        .LFSR_SEED (16'hACE1)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ready_for_mole (ready_for_mole),
        .timeout_start  (timeout_start),
        .level_number   (level_number),
        .led_number     (led_number),
        .timeout        (timeout),
        .mole_index     (mole_index)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        if (s == 16'h0000) return 16'hACE1;
        if (s[0]) return (s >> 1) ^ 16'hB400;
        return s >> 1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 16'hACE1;
        else        m_lfsr <= lfsr_step(m_lfsr);
    end

    function automatic int pick_model(input logic [15:0] s, input int prev);
        int c;
        c = int'(s[4:0]);
        if (c >= 18) c = c - 18;
        if (c >= 18) c = c - 18;
        if (c == prev) c = (c == 17) ? 0 : c + 1;
        return c;
    endfunction

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load_mole(input string tag);
        int e;
        e = pick_model(m_lfsr, m_prev);
        ready_for_mole = 1'b1;
        step(1);
        ready_for_mole = 1'b0;
        expect_eq({tag, "_idx"}, 32'(mole_index), 32'(e));
        expect_eq({tag, "_led"}, 32'(led_number), 32'(1) << e);
        expect_eq({tag, "_to"}, 32'(timeout), 32'(1));
        m_prev = e;
    endtask

    initial begin
        int   last_obs;
        logic [31:0] seen;

        // 1: reset, level 1, 12-cycle lifetime
        step(2);
        expect_eq("rst_led", 32'(led_number), 0);
        expect_eq("rst_idx", 32'(mole_index), 0);
        expect_eq("rst_to", 32'(timeout), 1);
        rst_n = 1'b1;
        level_number = 2'd1;
        step(1);
        load_mole("t1_load");
        expect_eq("t1_range", 32'(mole_index < 5'd18), 1);
        timeout_start = 1'b1;
        step(11);
        expect_eq("t1_to_11", 32'(timeout), 1);
        step(1);
        expect_eq("t1_to_12", 32'(timeout), 0);
        expect_eq("t1_led_12", 32'(led_number), 0);

        // 2: level 3, hit after 2 cycles, back to idle
        level_number = 2'd3;
        timeout_start = 1'b0;
        step(1);
        load_mole("t2_load");
        timeout_start = 1'b1;
        step(2);
        timeout_start = 1'b0;
        step(1);
        expect_eq("t2_hit_to", 32'(timeout), 1);
        expect_eq("t2_hit_led", 32'(led_number), 0);
        step(5);
        expect_eq("t2_idle_to", 32'(timeout), 1);
        expect_eq("t2_idle_led", 32'(led_number), 0);
        load_mole("t2_reload");
        timeout_start = 1'b1;
        step(3);
        expect_eq("t2_to_3", 32'(timeout), 1);
        step(1);
        expect_eq("t2_to_4", 32'(timeout), 0);

        // 3: 200 load/expire rounds, timeout_start held high through each load
        last_obs = int'(mole_index);
        seen = '0;
        for (int i = 0; i < 200; i++) begin
            load_mole("t3_load");
            expect_eq("t3_range", 32'(mole_index < 5'd18), 1);
            expect_eq("t3_consec", 32'(int'(mole_index) != last_obs), 1);
            last_obs = int'(mole_index);
            seen[mole_index] = 1'b1;
            step(4);
            expect_eq("t3_expire", 32'(timeout), 0);
        end
        expect_eq("t3_cover", seen, 32'h0003_FFFF);

        // 4: ready_for_mole on the final tick
        level_number = 2'd1;
        step(1);
        load_mole("t4_load");
        step(11);
        expect_eq("t4_to_11", 32'(timeout), 1);
        load_mole("t4_final_tick");
        step(11);
        expect_eq("t4_new_to_11", 32'(timeout), 1);
        step(1);
        expect_eq("t4_new_to_12", 32'(timeout), 0);

        // 5: asynchronous reset mid-RUNNING
        load_mole("t5_load");
        step(5);
        #3;
        rst_n = 1'b0;
        #1;
        expect_eq("t5_async_led", 32'(led_number), 0);
        expect_eq("t5_async_to", 32'(timeout), 1);
        expect_eq("t5_async_idx", 32'(mole_index), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        expect_eq("t5_hold_led", 32'(led_number), 0);
        rst_n = 1'b1;
        timeout_start = 1'b0;
        m_prev = 0;
        load_mole("t5_first");
        expect_eq("t5_seed_idx", 32'(mole_index), 1);

        // 6: level change mid-mole takes effect only after the expired latch
        timeout_start = 1'b1;
        step(3);
        level_number = 2'd2;
        step(8);
        expect_eq("t6_to_11", 32'(timeout), 1);
        step(1);
        expect_eq("t6_to_12", 32'(timeout), 0);
        step(1);
        load_mole("t6_load_l2");
        step(7);
        expect_eq("t6_l2_to_7", 32'(timeout), 1);
        step(1);
        expect_eq("t6_l2_to_8", 32'(timeout), 0);
        expect_eq("t6_l2_led_8", 32'(led_number), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
